// File: rtl/ram_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous RAM.
// Partial stores are done as read-modify-write; out-of-range addresses are rejected without a RAM access.
module ram_arbiter #(
    parameter int unsigned RAM_SIZE = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        ram_enable,
    output logic        ram_write,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);
    localparam logic        PORT_I    = 1'b0;
    localparam logic        PORT_D    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        port_q, port_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        err_q, err_d;
    logic [31:0] merged_q, merged_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= PORT_I;
            last_grant_q <= PORT_I;
            addr_q       <= 32'h0;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            err_q        <= 1'b0;
            merged_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            err_q        <= err_d;
            merged_q     <= merged_d;
        end
    end

    always_comb begin
        logic grant_data;
        logic ack;
        logic [31:0] rdata;

        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        err_d        = err_q;
        merged_d     = merged_q;
        grant_data   = 1'b0;
        ack          = 1'b0;
        rdata        = 32'h0;
        ram_enable   = 1'b0;
        ram_write    = 1'b0;
        ram_addr     = 32'h0;
        ram_wdata    = 32'h0;
        i_ack        = 1'b0;
        i_rdata      = 32'h0;
        i_err        = 1'b0;
        d_ack        = 1'b0;
        d_rdata      = 32'h0;
        d_err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that lost last time wins
                    grant_data   = d_req && (!i_req || (last_grant_q == PORT_I));
                    port_d       = grant_data ? PORT_D : PORT_I;
                    last_grant_d = port_d;
                    addr_d       = grant_data ? d_addr : i_addr;
                    write_d      = grant_data && d_write;
                    wdata_d      = grant_data ? d_wdata : 32'h0;
                    wstrb_d      = grant_data ? d_wstrb : 4'h0;
                    err_d        = (addr_d >= RAM_LIMIT);
                    state_d      = err_d ? RESP : CMD;
                end
            end
            CMD: begin
                ram_enable = 1'b1;
                ram_addr   = addr_q;
                ram_wdata  = wdata_q;
                ram_write  = write_q && (wstrb_q == 4'hF);
                state_d    = RESP;
            end
            RESP: begin
                state_d = IDLE;
                ack     = 1'b1;
                if (!err_q && !write_q) begin
                    rdata = ram_rdata;
                end else if (!err_q && (wstrb_q != 4'hF) && (wstrb_q != 4'h0)) begin
                    // Partial store: merge enabled lanes over the word just read
                    for (int n = 0; n < 4; n++) begin
                        merged_d[8*n +: 8] = wstrb_q[n] ? wdata_q[8*n +: 8] : ram_rdata[8*n +: 8];
                    end
                    ack     = 1'b0;
                    state_d = WR;
                end
            end
            WR: begin
                ram_enable = 1'b1;
                ram_write  = 1'b1;
                ram_addr   = addr_q;
                ram_wdata  = merged_q;
                ack        = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (port_q == PORT_D) begin
            d_ack   = ack;
            d_rdata = rdata;
            d_err   = ack && err_q;
        end else begin
            i_ack   = ack;
            i_rdata = rdata;
            i_err   = ack && err_q;
        end

        // An access in flight when reset arrives is abandoned silently
        if (rst) begin
            ram_enable = 1'b0;
            ram_write  = 1'b0;
            i_ack      = 1'b0;
            i_rdata    = 32'h0;
            i_err      = 1'b0;
            d_ack      = 1'b0;
            d_rdata    = 32'h0;
            d_err      = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, vector table plus scoreboard of expected acks,
// and hand-written sequences for arbitration ties and reset mid-access.
module tb_ram_arbiter;

    localparam int unsigned RAM_SIZE = 32768;
    localparam int unsigned WORDS    = RAM_SIZE / 4;
    localparam int unsigned IW       = $clog2(WORDS);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_write, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        ram_enable, ram_write;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    ram_arbiter #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_enable(ram_enable), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one-cycle read latency, with a backdoor write port for preloading
    logic [31:0]   mem [WORDS];
    logic          bd_we;
    logic [IW-1:0] bd_idx;
    logic [31:0]   bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (ram_enable) begin
            if (ram_write) mem[ram_addr[IW+1:2]] <= ram_wdata;
            else           ram_rdata <= mem[ram_addr[IW+1:2]];
        end
    end

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
        logic [31:0] wword;
    } vec_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        bit          wr_chk;
        logic [31:0] wword;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = IW'(idx);
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] rdata, input bit err, input int lat,
                            input bit wr_chk, input logic [31:0] wword);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.err = err; e.lat = lat; e.wr_chk = wr_chk; e.wword = wword;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        push_exp(v.is_d, v.exp_rdata, v.exp_err, v.lat, v.lat == 3, v.wword);
    endtask

    // Waits for n acks, popping and comparing a scoreboard entry on each; drops the acked request
    task automatic serve(input int n_acks, input bit chk_cmd, input logic [31:0] cmd_addr,
                         input bit cmd_wr, input bit no_ram);
        int   cyc = 0;
        int   got = 0;
        bit   ram_seen = 1'b0;
        exp_t e;
        while (got < n_acks && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ram_enable) ram_seen = 1'b1;
            if (chk_cmd && cyc == 1) begin
                chk("cmd_enable", 32'(ram_enable), 32'h1);
                chk("cmd_addr", ram_addr, cmd_addr);
                chk("cmd_write", 32'(ram_write), 32'(cmd_wr));
            end
            if (i_ack || d_ack) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b with empty scoreboard", i_ack, d_ack);
                end else begin
                    e = sb.pop_front();
                    chk("ack_i", 32'(i_ack), 32'(!e.is_d));
                    chk("ack_d", 32'(d_ack), 32'(e.is_d));
                    chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                    chk("err", 32'(e.is_d ? d_err : i_err), 32'(e.err));
                    chk("latency", 32'(cyc), 32'(e.lat));
                    if (e.wr_chk) begin
                        chk("wr_write", 32'(ram_enable && ram_write), 32'h1);
                        chk("wr_wdata", ram_wdata, e.wword);
                    end
                    if (e.is_d) d_req = 1'b0;
                    else        i_req = 1'b0;
                end
                got++;
            end
        end
        if (got < n_acks) begin
            checks++; errors++;
            $display("FAIL timeout: got %0d acks expected %0d", got, n_acks);
            i_req = 1'b0; d_req = 1'b0;
        end
        if (no_ram) chk("no_ram_access", 32'(ram_seen), 32'h0);
        @(negedge clk);
        chk("idle_quiet", 32'({i_ack, d_ack, ram_enable}), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;

        poke(4, 32'hDEADBEEF);
        poke(8, 32'h55667788);
        poke(16, 32'h11223344);
        poke(17, 32'h0);
        poke(18, 32'h0);
        poke(20, 32'h01020304);
        poke(WORDS - 1, 32'h0BADF00D);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ram_enable", 32'(ram_enable), 32'h0);
        chk("rst_ram_write", 32'(ram_write), 32'h0);
        chk("rst_i_ack", 32'(i_ack), 32'h0);
        chk("rst_d_ack", 32'(d_ack), 32'h0);
        chk("rst_i_err", 32'(i_err), 32'h0);
        chk("rst_d_err", 32'(d_err), 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);

        // First tie after reset: data served first, fetch afterwards
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h20;
        push_exp(1'b1, 32'h55667788, 1'b0, 2, 1'b0, 32'h0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b0, 5, 1'b0, 32'h0);
        serve(2, 1'b1, 32'h20, 1'b0, 1'b0);

        // Lone data grant, then a tie must go to fetch
        v = '{1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h55667788, 1'b0, 2, 32'h0};
        drive(v);
        serve(1, 1'b1, 32'h20, 1'b0, 1'b0);
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h20;
        push_exp(1'b0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0);
        push_exp(1'b1, 32'h55667788, 1'b0, 5, 1'b0, 32'h0);
        serve(2, 1'b1, 32'h10, 1'b0, 1'b0);

        //          is_d wr  addr            wdata          wstrb    exp_rdata      err   lat wword
        vt[0]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEADBEEF, 1'b0, 2, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h11223344, 1'b0, 2, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hAABBCCDD,  4'b0101, 32'h0,        1'b0, 3, 32'h11BB33DD};
        vt[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'h11BB33DD, 1'b0, 2, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFEF00D,  4'b1111, 32'h0,        1'b0, 2, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4'b0000, 32'hCAFEF00D, 1'b0, 2, 32'h0};
        vt[6]  = '{1'b1, 1'b1, 32'h0000_0044, 32'h12345678,  4'b0000, 32'h0,        1'b0, 2, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 32'h0000_0046, 32'h0,         4'b0000, 32'hCAFEF00D, 1'b0, 2, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 32'h0000_8000, 32'h0,         4'b0000, 32'h0,        1'b1, 1, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0,        1'b1, 1, 32'h0};
        vt[10] = '{1'b0, 1'b0, 32'h0000_7FFC, 32'h0,         4'b0000, 32'h0BADF00D, 1'b0, 2, 32'h0};
        vt[11] = '{1'b1, 1'b1, 32'h0000_7FFC, 32'hFF00FF00,  4'b1000, 32'h0,        1'b0, 3, 32'hFFADF00D};
        vt[12] = '{1'b0, 1'b0, 32'h0000_7FFC, 32'h0,         4'b0000, 32'hFFADF00D, 1'b0, 2, 32'h0};
        vt[13] = '{1'b1, 1'b1, 32'h0000_0048, 32'h0000AB00,  4'b0010, 32'h0,        1'b0, 3, 32'h0000AB00};
        vt[14] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         4'b0000, 32'h0000AB00, 1'b0, 2, 32'h0};
        vt[15] = '{1'b1, 1'b1, 32'h0000_8000, 32'hFFFFFFFF,  4'b1111, 32'h0,        1'b1, 1, 32'h0};

        for (int k = 0; k < 16; k++) begin
            drive(vt[k]);
            serve(1, !vt[k].exp_err, vt[k].addr, vt[k].wr && (vt[k].wstrb == 4'hF), vt[k].exp_err);
        end

        // Reset during RESP of a partial store abandons the write
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h50; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'b0011;
        @(negedge clk);
        chk("rmw_cmd_enable", 32'(ram_enable), 32'h1);
        @(negedge clk);
        chk("rmw_resp_no_ack", 32'(d_ack), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        d_req = 1'b0;
        rst   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({d_ack, i_ack, ram_enable}), 32'h0);
        end
        chk("post_rst_word", mem[20], 32'h01020304);
        v = '{1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 32'h01020304, 1'b0, 2, 32'h0};
        drive(v);
        serve(1, 1'b1, 32'h50, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: RAM_SIZE, 32768, RAM capacity in bytes (power of two, ≥ 8); word index is addr[log2(RAM_SIZE)-1:2].
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 i_req  input  1  instruction-fetch read request; held high until i_ack.
REQ-005 i_addr  input  32  fetch byte address; stable while i_req high.
REQ-006 i_ack  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata  output  32  fetch read word; valid only while i_ack high, else 0.
REQ-008 i_err  output  1  out-of-range flag; valid only while i_ack high, else 0.
REQ-009 d_req  input  1  data-port request; held high until d_ack.
REQ-010 d_write  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address; stable while d_req high.
REQ-012 d_wdata  input  32  store data, byte lanes per d_wstrb.
REQ-013 d_wstrb  input  4  store byte enables; bit n enables bits [8n+7:8n].
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 d_rdata  output  32  load word; valid only while d_ack high on a load, else 0.
REQ-016 d_err  output  1  out-of-range flag; valid only while d_ack high, else 0.
REQ-017 ram_enable  output  1  RAM port enable.
REQ-018 ram_write  output  1  RAM write (with ram_enable).
REQ-019 ram_addr  output  32  RAM byte address.
REQ-020 ram_wdata  output  32  RAM write word.
REQ-021 ram_rdata  input  32  RAM read word; valid the cycle after a read command (1-cycle latency); unchanged by writes.

Function
REQ-022 The FSM SHALL have states IDLE, CMD, RESP, WR.
REQ-023 In IDLE with any req high, the block SHALL latch port, address, write, wdata and wstrb, and enter CMD next cycle; with no req, it SHALL stay in IDLE.
REQ-024 Arbitration: a single pending request SHALL be granted; if both are pending, the port not granted last time SHALL win (last_grant flag, updated on each grant).
REQ-025 Range check: latched addr ≥ RAM_SIZE SHALL skip CMD and WR, go IDLE→RESP, and ack with err=1 and rdata=0; no RAM access.
REQ-026 CMD: ram_enable=1, ram_addr=latched addr, ram_wdata=latched wdata, ram_write=1 only for a store with wstrb=4'b1111, else 0 (read); next state RESP.
REQ-027 RESP, load or fetch: ack the granted port this cycle with rdata=ram_rdata; next state IDLE.
REQ-028 RESP, full-word store or store with wstrb=0: d_ack this cycle, d_rdata=0; wstrb=0 SHALL leave memory unmodified; next IDLE.
REQ-029 RESP, partial store (wstrb ∉ {0000,1111}): merge enabled lanes of wdata into ram_rdata, register the result, enter WR; no ack in RESP.
REQ-030 WR: ram_enable=1, ram_write=1, ram_addr=latched addr, ram_wdata=merged word; d_ack this cycle; next IDLE.
REQ-031 ram_enable SHALL be 1 only in CMD and WR; at most one ack SHALL be high per cycle.
REQ-032 Latency, req seen in IDLE at edge E0: ack high in the 2nd cycle after E0 (full access), 3rd (partial store), 1st (range error).
REQ-033 A req still high in IDLE after its ack SHALL be treated as a new request; requesters drop req at the edge ending the ack cycle.
REQ-034 addr[1:0] SHALL be passed to the RAM unchanged and otherwise ignored (word access).

Reset
REQ-035 On rst high at a clock edge: state=IDLE, last_grant=fetch (first tie goes to data), latched regs=0; ram_enable, ram_write, all acks, all errs SHALL be 0 the following cycle.
REQ-036 Reset in CMD, RESP or WR SHALL abandon the access: no ack, no WR write issued.

Verification
REQ-037 Fetch i_addr=0x10, RAM word 4 = 0xDEADBEEF -> CMD with ram_addr=0x10, ram_write=0; i_ack 2 cycles later, i_rdata=0xDEADBEEF.
REQ-038 i_req and d_req (load 0x20) asserted together after reset -> data served first, then fetch; next tie grants fetch.
REQ-039 Word 0x40 = 0x11223344, store d_wdata=0xAABBCCDD, wstrb=0101 -> read then WR writes 0x11BB33DD; d_ack in WR cycle only.
REQ-040 Load d_addr=0x8000 with RAM_SIZE=32768 -> d_ack next cycle, d_err=1, d_rdata=0, ram_enable never high.
REQ-041 rst asserted during RESP of a partial store -> no WR, no d_ack, word unchanged, state IDLE.
